// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: op encodings
// and signed min/max constants for any operand width up to CLA_MAX_W.
package cla_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } cla_op_e;

  localparam int CLA_MAX_W = 64;

  function automatic logic [CLA_MAX_W-1:0] cla_smax(input int w);
    return (CLA_MAX_W'(1) << (w - 1)) - CLA_MAX_W'(1);
  endfunction

  function automatic logic [CLA_MAX_W-1:0] cla_smin(input int w);
    return CLA_MAX_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result stream between a producer (master) and the adder (slave),
// each direction with its own valid/ready handshake.
interface cla_pipe_adder_if #(
  parameter int WIDTH = 32
);
  import cla_pkg::*;

  logic             in_valid;
  logic             in_ready;
  cla_op_e          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, op, a, b, c_in, sat, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf, zero
  );

  modport slave (
    input  in_valid, op, a, b, c_in, sat, out_ready,
    output in_ready, out_valid, sum, c_out, ovf, zero
  );

endinterface

// File: rtl/cla_group.sv
// One GROUP-bit lookahead cell: group generate/propagate, plus the carry into
// every bit of the group given the group's carry-in.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] i_g,
  input  logic [GROUP-1:0] i_p,
  input  logic             i_c,
  output logic             o_g,
  output logic             o_p,
  output logic [GROUP-1:0] o_c
);

  logic w_c;
  logic w_gg;

  always_comb begin
    w_c  = i_c;
    w_gg = 1'b0;
    o_c  = '0;
    for (int k = 0; k < GROUP; k++) begin
      o_c[k] = w_c;
      w_c    = i_g[k] | (i_p[k] & w_c);
      w_gg   = i_g[k] | (i_p[k] & w_gg);
    end
    o_g = w_gg;
    o_p = &i_p;
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead add/sub (ADD/SUB/ADC/SBB) with flags and
// valid/ready flow control. Define CLA_SAT_EN to enable signed saturation on sat.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input logic             clk,
  input logic             rst_n,
  cla_pipe_adder_if.slave bus
);

  localparam int NG = WIDTH / GROUP;

  if (WIDTH % GROUP != 0) begin : g_chk_width
    $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
  end
  if (GROUP < 2 || GROUP > 8 || (GROUP & (GROUP - 1)) != 0) begin : g_chk_group
    $error("cla_pipe_adder: GROUP must be a power of 2 in 2..8");
  end

  function automatic logic [NG-1:0] group_cins(input logic [NG-1:0] gg,
                                               input logic [NG-1:0] gp,
                                               input logic          cin);
    logic [NG-1:0] res;
    logic          c;
    c = cin;
    for (int j = 0; j < NG; j++) begin
      res[j] = c;
      c      = gg[j] | (gp[j] & c);
    end
    return res;
  endfunction

  logic w_s2_adv, w_s1_adv, w_accept;
  logic r_vld_p1, r_vld_p2;

  assign w_s2_adv     = !r_vld_p2 | bus.out_ready;
  assign w_s1_adv     = r_vld_p1 & w_s2_adv;
  assign bus.in_ready = !r_vld_p1 | w_s1_adv;
  assign w_accept     = bus.in_valid & bus.in_ready;

  // ---- Stage 1: operand conditioning, group G/P, cross-group carries ----
  logic [WIDTH-1:0] w_b_eff, w_g1, w_p1, w_c1_unused;
  logic [NG-1:0]    w_gg1, w_gp1, w_gc1;
  logic             w_cin;

  always_comb begin
    w_b_eff = bus.op[0] ? ~bus.b : bus.b;
    w_cin   = 1'b0;
    case (bus.op)
      OP_ADD: w_cin = 1'b0;
      OP_SUB: w_cin = 1'b1;
      OP_ADC: w_cin = bus.c_in;
      OP_SBB: w_cin = ~bus.c_in;
    endcase
  end

  assign w_g1  = bus.a & w_b_eff;
  assign w_p1  = bus.a ^ w_b_eff;
  assign w_gc1 = group_cins(w_gg1, w_gp1, w_cin);

  for (genvar j = 0; j < NG; j++) begin : g_s1
    cla_group #(.GROUP(GROUP)) u_grp (
      .i_g (w_g1[j*GROUP +: GROUP]),
      .i_p (w_p1[j*GROUP +: GROUP]),
      .i_c (1'b0),
      .o_g (w_gg1[j]),
      .o_p (w_gp1[j]),
      .o_c (w_c1_unused[j*GROUP +: GROUP])
    );
  end

  logic [WIDTH-1:0] r_a_p1, r_b_p1, r_p_p1;
  logic [NG-1:0]    r_gc_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_a_p1   <= '0;
      r_b_p1   <= '0;
      r_p_p1   <= '0;
      r_gc_p1  <= '0;
    end else begin
      if (bus.in_ready) r_vld_p1 <= bus.in_valid;
      if (w_accept) begin
        r_a_p1  <= bus.a;
        r_b_p1  <= w_b_eff;
        r_p_p1  <= w_p1;
        r_gc_p1 <= w_gc1;
      end
    end
  end

  // ---- Stage 2: intra-group carries, sum and flags ----
  logic [WIDTH-1:0] w_g2, w_c2, w_sum_raw, w_sum2;
  logic [NG-1:0]    w_gg2_unused, w_gp2_unused;
  logic             w_cout2, w_ovf2;

  assign w_g2 = r_a_p1 & r_b_p1;

  for (genvar j = 0; j < NG; j++) begin : g_s2
    cla_group #(.GROUP(GROUP)) u_grp (
      .i_g (w_g2[j*GROUP +: GROUP]),
      .i_p (r_p_p1[j*GROUP +: GROUP]),
      .i_c (r_gc_p1[j]),
      .o_g (w_gg2_unused[j]),
      .o_p (w_gp2_unused[j]),
      .o_c (w_c2[j*GROUP +: GROUP])
    );
  end

  assign w_sum_raw = r_p_p1 ^ w_c2;
  assign w_cout2   = w_g2[WIDTH-1] | (r_p_p1[WIDTH-1] & w_c2[WIDTH-1]);
  assign w_ovf2    = w_c2[WIDTH-1] ^ w_cout2;

`ifdef CLA_SAT_EN
  localparam logic [CLA_MAX_W-1:0] SMAX_FULL = cla_smax(WIDTH);
  localparam logic [CLA_MAX_W-1:0] SMIN_FULL = cla_smin(WIDTH);
  localparam logic signed [WIDTH-1:0] SMAX = SMAX_FULL[WIDTH-1:0];
  localparam logic signed [WIDTH-1:0] SMIN = SMIN_FULL[WIDTH-1:0];

  // Overflow direction follows operand A's sign; B_eff had the same sign.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] s,
                                                input logic clip,
                                                input logic neg);
    if (!clip) return s;
    return neg ? SMIN : SMAX;
  endfunction

  logic r_sat_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_sat_p1 <= 1'b0;
    else if (w_accept) r_sat_p1 <= bus.sat;
  end

  assign w_sum2 = saturate(w_sum_raw, r_sat_p1 & w_ovf2, r_a_p1[WIDTH-1]);
`else
  logic w_sat_unused;
  assign w_sat_unused = bus.sat;
  assign w_sum2       = w_sum_raw;
`endif

  logic [WIDTH-1:0] r_sum_p2;
  logic             r_cout_p2, r_ovf_p2, r_zero_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2  <= 1'b0;
      r_sum_p2  <= '0;
      r_cout_p2 <= 1'b0;
      r_ovf_p2  <= 1'b0;
      r_zero_p2 <= 1'b0;
    end else begin
      if (w_s2_adv) r_vld_p2 <= r_vld_p1;
      if (w_s1_adv) begin
        r_sum_p2  <= w_sum2;
        r_cout_p2 <= w_cout2;
        r_ovf_p2  <= w_ovf2;
        r_zero_p2 <= ~|w_sum2;
      end
    end
  end

  assign bus.out_valid = r_vld_p2;
  assign bus.sum       = r_sum_p2;
  assign bus.c_out     = r_cout_p2;
  assign bus.ovf       = r_ovf_p2;
  assign bus.zero      = r_zero_p2;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed corner cases, backpressure, async reset
// and a randomized stream scored against an arithmetic reference model.
module tb_cla_pipe_adder;
  import cla_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla_pipe_adder_if #(.WIDTH(W)) bus ();

  cla_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sat;
  } beat_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         c;
    logic         o;
    logic         z;
  } res_t;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    occ      = 0;
  beat_t pend[$];
  res_t  expq[$];

  function automatic res_t model(input beat_t bt);
    res_t         r;
    logic [W-1:0] be;
    logic         cin;
    logic [W:0]   full;
    longint       s, smax, smin;
    be = bt.op[0] ? ~bt.b : bt.b;
    case (bt.op)
      2'b00:   cin = 1'b0;
      2'b01:   cin = 1'b1;
      2'b10:   cin = bt.ci;
      default: cin = ~bt.ci;
    endcase
    full  = {1'b0, bt.a} + {1'b0, be} + (W+1)'(cin);
    s     = longint'($signed(bt.a)) + longint'($signed(be)) + longint'(cin);
    smax  = (longint'(1) <<< (W - 1)) - 1;
    smin  = -(longint'(1) <<< (W - 1));
    r.sum = full[W-1:0];
    r.c   = full[W];
    r.o   = (s > smax) || (s < smin);
`ifdef CLA_SAT_EN
    if (bt.sat && r.o) r.sum = bt.a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    r.z = (r.sum == '0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input beat_t bt);
    bus.in_valid = 1'b1;
    bus.op       = cla_op_e'(bt.op);
    bus.a        = bt.a;
    bus.b        = bt.b;
    bus.c_in     = bt.ci;
    bus.sat      = bt.sat;
  endtask

  task automatic chk_res(input string tag, input res_t e);
    chk({tag, ".sum"},  bus.sum, e.sum);
    chk({tag, ".cout"}, W'(bus.c_out), W'(e.c));
    chk({tag, ".ovf"},  W'(bus.ovf),   W'(e.o));
    chk({tag, ".zero"}, W'(bus.zero),  W'(e.z));
  endtask

  // One beat in isolation: checks acceptance, exact 2-clock latency and result.
  task automatic single(input string tag, input beat_t bt, input res_t e);
    drive(bt);
    bus.out_ready = 1'b1;
    #1;
    chk({tag, ".in_ready"}, W'(bus.in_ready), W'(1));
    tick();
    bus.in_valid = 1'b0;
    chk({tag, ".lat1"}, W'(bus.out_valid), W'(0));
    tick();
    chk({tag, ".lat2"}, W'(bus.out_valid), W'(1));
    chk_res(tag, e);
    tick();
    chk({tag, ".drain"}, W'(bus.out_valid), W'(0));
  endtask

  function automatic beat_t rand_beat();
    beat_t bt;
    logic [W-1:0] pick [5];
    pick[0] = W'($urandom);
    pick[1] = '0;
    pick[2] = '1;
    pick[3] = {1'b0, {(W-1){1'b1}}};
    pick[4] = {1'b1, {(W-1){1'b0}}};
    bt.op  = 2'($urandom_range(3));
    bt.a   = ($urandom_range(2) == 0) ? pick[$urandom_range(4)] : W'($urandom);
    bt.b   = ($urandom_range(2) == 0) ? pick[$urandom_range(4)] : W'($urandom);
    bt.ci  = 1'($urandom_range(1));
    bt.sat = 1'($urandom_range(1));
    return bt;
  endfunction

  // Streams everything in pend; out_ready held low for the first `hold` cycles.
  task automatic run_stream(input int pct, input int hold, input int budget);
    int   cyc;
    logic stall;
    res_t held, e;
    cyc   = 0;
    stall = 1'b0;
    held  = '{default: '0};
    while ((pend.size() > 0 || expq.size() > 0) && cyc < budget) begin
      if (pend.size() > 0) drive(pend[0]);
      else bus.in_valid = 1'b0;
      bus.out_ready = (cyc < hold) ? 1'b0 : ($urandom_range(99) < pct);
      #1;
      chk("in_ready", W'(bus.in_ready), W'(!(occ == 2 && !bus.out_ready)));
      if (stall) begin
        chk("hold.valid", W'(bus.out_valid), W'(1));
        chk_res("hold", held);
      end
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(model(pend.pop_front()));
        occ++;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("no_dup", W'(expq.size() > 0), W'(1));
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk_res("stream", e);
        end
        occ--;
      end
      stall    = bus.out_valid && !bus.out_ready;
      held.sum = bus.sum;
      held.c   = bus.c_out;
      held.o   = bus.ovf;
      held.z   = bus.zero;
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("stream_done", W'(pend.size() + expq.size()), W'(0));
  endtask

  initial begin
    beat_t bt;
    res_t  e;

    bus.in_valid  = 1'b0;
    bus.op        = OP_ADD;
    bus.a         = '0;
    bus.b         = '0;
    bus.c_in      = 1'b0;
    bus.sat       = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) tick();
    chk("rst.out_valid", W'(bus.out_valid), W'(0));
    chk("rst.sum",       bus.sum, '0);
    chk("rst.cout",      W'(bus.c_out), W'(0));
    chk("rst.ovf",       W'(bus.ovf), W'(0));
    chk("rst.zero",      W'(bus.zero), W'(0));
    chk("rst.in_ready",  W'(bus.in_ready), W'(1));
    rst_n = 1'b1;
    tick();

    bt = '{2'b00, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0};
    single("add_ovf", bt, '{32'h8000_0000, 1'b0, 1'b1, 1'b0});
    bt = '{2'b01, 32'h5, 32'h5, 1'b0, 1'b0};
    single("sub_eq", bt, '{32'h0, 1'b1, 1'b0, 1'b1});
    bt = '{2'b01, 32'h0, 32'h1, 1'b0, 1'b0};
    single("sub_borrow", bt, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
    bt = '{2'b10, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0};
    single("adc_wrap", bt, '{32'h0, 1'b1, 1'b0, 1'b1});
    bt = '{2'b11, 32'h3, 32'h1, 1'b1, 1'b0};
    single("sbb", bt, '{32'h1, 1'b1, 1'b0, 1'b0});
`ifdef CLA_SAT_EN
    bt = '{2'b00, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1};
    single("sat_add", bt, '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0});
    bt = '{2'b01, 32'h8000_0000, 32'h1, 1'b0, 1'b1};
    single("sat_sub", bt, '{32'h8000_0000, 1'b1, 1'b1, 1'b0});
`else
    bt = '{2'b00, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1};
    single("sat_add", bt, '{32'h8000_0000, 1'b0, 1'b1, 1'b0});
    bt = '{2'b01, 32'h8000_0000, 32'h1, 1'b0, 1'b1};
    single("sat_sub", bt, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
`endif

    for (int i = 0; i < 4; i++) pend.push_back(rand_beat());
    run_stream(100, 5, 200);

    for (int i = 0; i < 40; i++) pend.push_back(rand_beat());
    run_stream(70, 0, 2000);

    bus.out_ready = 1'b0;
    bt = '{2'b00, 32'h1, 32'h2, 1'b0, 1'b0};
    drive(bt);
    tick();
    bt = '{2'b00, 32'h10, 32'h20, 1'b0, 1'b0};
    drive(bt);
    tick();
    bus.in_valid = 1'b0;
    chk("inflight.valid", W'(bus.out_valid), W'(1));
    chk("inflight.sum",   bus.sum, 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.out_valid", W'(bus.out_valid), W'(0));
    chk("arst.sum",       bus.sum, '0);
    chk("arst.cout",      W'(bus.c_out), W'(0));
    chk("arst.zero",      W'(bus.zero), W'(0));
    tick();
    rst_n = 1'b1;
    occ   = 0;
    tick();
    chk("post_rst.out_valid", W'(bus.out_valid), W'(0));
    bt = '{2'b00, 32'd10, 32'd20, 1'b0, 1'b0};
    e  = model(bt);
    chk("post_rst.model", e.sum, 32'd30);
    single("post_rst", bt, '{32'd30, 1'b0, 1'b0, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
